// File: rtl/vending_pkg.sv
// Shared types, coin encoding and price table for the vending-machine controller.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CREDIT   = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_t;

  localparam logic [1:0] COIN_1  = 2'd0;
  localparam logic [1:0] COIN_5  = 2'd1;
  localparam logic [1:0] COIN_10 = 2'd2;
  localparam logic [1:0] COIN_25 = 2'd3;

  function automatic logic [4:0] coin_value(input logic [1:0] coin);
    case (coin)
      COIN_1:  coin_value = 5'd1;
      COIN_5:  coin_value = 5'd5;
      COIN_10: coin_value = 5'd10;
      default: coin_value = 5'd25;
    endcase
  endfunction

  function automatic logic [6:0] price(input logic [1:0] item);
    case (item)
      2'd0:    price = 7'd15;
      2'd1:    price = 7'd25;
      2'd2:    price = 7'd40;
      default: price = 7'd65;
    endcase
  endfunction

  // Greedy change: largest denomination not exceeding the remaining credit.
  function automatic logic [1:0] largest_coin(input logic [31:0] amount);
    if (amount >= 32'd25)      largest_coin = COIN_25;
    else if (amount >= 32'd10) largest_coin = COIN_10;
    else if (amount >= 32'd5)  largest_coin = COIN_5;
    else                       largest_coin = COIN_1;
  endfunction

endpackage

// File: rtl/vending_timer.sv
// Loadable down-counter; falls back to zero whenever it is neither loaded nor counting.
module vending_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - W'(1);
    end else begin
      count <= '0;
    end
  end

  assign last = (count == W'(1));

endmodule

// File: rtl/vending_ctrl.sv
// Vending sequencer: coin credit, price check, timed dispense strobe and greedy change payout.
module vending_ctrl
  import vending_pkg::*;
#(
  parameter int unsigned CREDIT_W     = 8,
  parameter int unsigned DISPENSE_CYC = 4,
  parameter int unsigned TIMEOUT_CYC  = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                sel_valid,
  input  logic [1:0]          sel_item,
  input  logic                cancel,
  input  logic                change_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense_valid,
  output logic [1:0]          dispense_item,
  output logic                change_valid,
  output logic [1:0]          change_coin,
  output logic                coin_reject,
  output logic                err_low,
  output logic                busy
);

  localparam int unsigned CW1  = CREDIT_W + 1;
  localparam int unsigned TMAX = (TIMEOUT_CYC > DISPENSE_CYC) ? TIMEOUT_CYC : DISPENSE_CYC;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [1:0]          item_q, item_d;
  logic                rej_q, rej_d;
  logic                err_q, err_d;

  logic                tmr_load, tmr_dec, tmr_last;
  logic [TW-1:0]       tmr_val, tmr_count;

  logic [CW1-1:0]      coin_sum;
  logic [CREDIT_W-1:0] price_w;
  logic [4:0]          change_val;
  logic                any_event;

  // Timeout and dispense length never overlap, so one counter serves both.
  vending_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (tmr_val),
    .count    (tmr_count),
    .last     (tmr_last)
  );

  assign coin_sum   = {1'b0, credit_q} + CW1'(coin_value(coin_type));
  assign price_w    = CREDIT_W'(price(sel_item));
  assign change_val = coin_value(largest_coin(32'(credit_q)));
  assign any_event  = coin_valid | sel_valid | cancel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      credit_q <= '0;
      item_q   <= '0;
      rej_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      item_q   <= item_d;
      rej_q    <= rej_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    item_d   = item_q;
    rej_d    = 1'b0;
    err_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = '0;

    case (state_q)
      IDLE, CREDIT: begin
        // Priority: cancel, then an affordable select, then the coin.
        if (cancel) begin
          rej_d = coin_valid;
          if (state_q == CREDIT) state_d = CHANGE;
        end else if (sel_valid && credit_q >= price_w) begin
          state_d  = DISPENSE;
          credit_d = credit_q - price_w;
          item_d   = sel_item;
          rej_d    = coin_valid;
        end else begin
          err_d = sel_valid;
          if (coin_valid) begin
            if (!coin_sum[CREDIT_W]) begin
              credit_d = coin_sum[CREDIT_W-1:0];
              state_d  = CREDIT;
            end else begin
              rej_d = 1'b1;
            end
          end else if (state_q == CREDIT && !sel_valid && tmr_last) begin
            state_d = CHANGE;
          end
        end

        if (state_d == DISPENSE) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(DISPENSE_CYC);
        end else if (state_d == CREDIT && any_event) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(TIMEOUT_CYC);
        end else if (state_d == CREDIT) begin
          tmr_dec = 1'b1;
        end
      end

      DISPENSE: begin
        rej_d = coin_valid;
        if (tmr_last) begin
          state_d = (credit_q != '0) ? CHANGE : IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      CHANGE: begin
        rej_d = coin_valid;
        if (credit_q == '0) begin
          state_d = IDLE;
        end else if (change_ready) begin
          credit_d = credit_q - CREDIT_W'(change_val);
          if (credit_d == '0) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign credit         = credit_q;
  assign dispense_valid = (state_q == DISPENSE);
  assign dispense_item  = item_q;
  assign change_valid   = (state_q == CHANGE) && (credit_q != '0);
  assign change_coin    = change_valid ? largest_coin(32'(credit_q)) : COIN_1;
  assign coin_reject    = rej_q;
  assign err_low        = err_q;
  assign busy           = (state_q == DISPENSE) || (state_q == CHANGE);

endmodule

// File: tb/tb_vending_ctrl.sv
// Directed vector bench for vending_ctrl (DISPENSE_CYC=4, TIMEOUT_CYC=8).
module tb_vending_ctrl;

  logic       clk;
  logic       rst_n;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       sel_valid;
  logic [1:0] sel_item;
  logic       cancel;
  logic       change_ready;
  logic [7:0] credit;
  logic       dispense_valid;
  logic [1:0] dispense_item;
  logic       change_valid;
  logic [1:0] change_coin;
  logic       coin_reject;
  logic       err_low;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string      nm;
    logic       cv;
    logic [1:0] ct;
    logic       sv;
    logic [1:0] si;
    logic       can;
    logic       rdy;
    logic [7:0] cr;
    logic       dv;
    logic [1:0] di;
    logic       chv;
    logic [1:0] cc;
    logic       rej;
    logic       err;
    logic       bsy;
  } vec_t;

  vec_t vq[$];

  vending_ctrl #(
    .CREDIT_W     (8),
    .DISPENSE_CYC (4),
    .TIMEOUT_CYC  (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .coin_valid     (coin_valid),
    .coin_type      (coin_type),
    .sel_valid      (sel_valid),
    .sel_item       (sel_item),
    .cancel         (cancel),
    .change_ready   (change_ready),
    .credit         (credit),
    .dispense_valid (dispense_valid),
    .dispense_item  (dispense_item),
    .change_valid   (change_valid),
    .change_coin    (change_coin),
    .coin_reject    (coin_reject),
    .err_low        (err_low),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs: cv ct sv si can rdy | expected after the edge: cr dv di chv cc rej err bsy
  task automatic add(input string nm, input int cv, input int ct, input int sv, input int si,
                     input int can, input int rdy, input int cr, input int dv, input int di,
                     input int chv, input int cc, input int rej, input int err, input int bsy);
    vec_t v;
    v.nm  = nm;
    v.cv  = 1'(cv);  v.ct = 2'(ct);  v.sv  = 1'(sv);  v.si  = 2'(si);
    v.can = 1'(can); v.rdy = 1'(rdy);
    v.cr  = 8'(cr);  v.dv = 1'(dv);  v.di  = 2'(di);  v.chv = 1'(chv);
    v.cc  = 2'(cc);  v.rej = 1'(rej); v.err = 1'(err); v.bsy = 1'(bsy);
    vq.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    logic [16:0] act, exp;
    @(negedge clk);
    coin_valid   = v.cv;
    coin_type    = v.ct;
    sel_valid    = v.sv;
    sel_item     = v.si;
    cancel       = v.can;
    change_ready = v.rdy;
    @(posedge clk);
    #1;
    // dispense_item is only defined while dispense_valid is high
    exp = {v.cr, v.dv, (v.dv ? v.di : 2'b00), v.chv, v.cc, v.rej, v.err, v.bsy};
    act = {credit, dispense_valid, (v.dv ? dispense_item : 2'b00), change_valid, change_coin,
           coin_reject, err_low, busy};
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got cr=%0d dv=%b di=%0d chv=%b cc=%0d rej=%b err=%b busy=%b, want cr=%0d dv=%b di=%0d chv=%b cc=%0d rej=%b err=%b busy=%b",
               v.nm, credit, dispense_valid, dispense_item, change_valid, change_coin,
               coin_reject, err_low, busy, v.cr, v.dv, v.di, v.chv, v.cc, v.rej, v.err, v.bsy);
    end
  endtask

  task automatic check_zero(input string nm);
    logic [16:0] act;
    act = {credit, dispense_valid, dispense_item, change_valid, change_coin,
           coin_reject, err_low, busy};
    n_checks++;
    if (act !== '0) begin
      n_errors++;
      $display("FAIL %s: got outputs=%h, want all zero", nm, act);
    end
  endtask

  task automatic idle_inputs();
    coin_valid   = 1'b0;
    coin_type    = 2'd0;
    sel_valid    = 1'b0;
    sel_item     = 2'd0;
    cancel       = 1'b0;
    change_ready = 1'b0;
  endtask

  initial begin
    int pay_cr[9];
    int pay_cc[9];
    vec_t hv;

    idle_inputs();
    rst_n = 1'b0;

    // A: 25+10+5, select item2 (40); select/cancel ignored and coin rejected while dispensing
    add("A1", 1,3, 0,0, 0,0,  25,0,0, 0,0, 0,0,0);
    add("A2", 1,2, 0,0, 0,0,  35,0,0, 0,0, 0,0,0);
    add("A3", 1,1, 0,0, 0,0,  40,0,0, 0,0, 0,0,0);
    add("A4", 0,0, 1,2, 0,0,   0,1,2, 0,0, 0,0,1);
    add("A5", 0,0, 0,0, 1,0,   0,1,2, 0,0, 0,0,1);
    add("A6", 0,0, 1,0, 0,0,   0,1,2, 0,0, 0,0,1);
    add("A7", 1,0, 0,0, 0,0,   0,1,2, 0,0, 1,0,1);
    add("A8", 0,0, 0,0, 0,0,   0,0,0, 0,0, 0,0,0);

    // B: 75 credit, item3 (65), change 10 held while ready low
    add("B1", 1,3, 0,0, 0,0,  25,0,0, 0,0, 0,0,0);
    add("B2", 1,3, 0,0, 0,0,  50,0,0, 0,0, 0,0,0);
    add("B3", 1,3, 0,0, 0,0,  75,0,0, 0,0, 0,0,0);
    add("B4", 0,0, 1,3, 0,0,  10,1,3, 0,0, 0,0,1);
    for (int i = 5; i <= 7; i++)
      add($sformatf("B%0d", i), 0,0, 0,0, 0,0, 10,1,3, 0,0, 0,0,1);
    add("B8",  0,0, 0,0, 0,0,  10,0,0, 1,2, 0,0,1);
    add("B9",  0,0, 0,0, 0,0,  10,0,0, 1,2, 0,0,1);
    add("B10", 1,0, 0,0, 0,0,  10,0,0, 1,2, 1,0,1);
    add("B11", 0,0, 0,0, 0,0,  10,0,0, 1,2, 0,0,1);
    add("B12", 0,0, 0,0, 0,1,   0,0,0, 0,0, 0,0,0);

    // C: refused selects (coin still credited), cancel refund, cancel ignored in IDLE
    add("C0", 0,0, 1,0, 0,0,   0,0,0, 0,0, 0,1,0);
    add("C1", 1,2, 0,0, 0,0,  10,0,0, 0,0, 0,0,0);
    add("C2", 1,0, 1,1, 0,0,  11,0,0, 0,0, 0,1,0);
    add("C3", 0,0, 0,0, 1,0,  11,0,0, 1,2, 0,0,1);
    add("C4", 0,0, 0,0, 0,1,   1,0,0, 1,0, 0,0,1);
    add("C5", 0,0, 0,0, 0,1,   0,0,0, 0,0, 0,0,0);
    add("C6", 0,0, 0,0, 1,0,   0,0,0, 0,0, 0,0,0);

    // D: saturation at 255, vend item3 then greedy payout of 190
    for (int i = 1; i <= 10; i++)
      add($sformatf("D%0d", i), 1,3, 0,0, 0,0, 25*i,0,0, 0,0, 0,0,0);
    add("D11", 1,2, 0,0, 0,0, 250,0,0, 0,0, 1,0,0);
    add("D12", 1,1, 0,0, 0,0, 255,0,0, 0,0, 0,0,0);
    add("D13", 0,0, 1,3, 0,1, 190,1,3, 0,0, 0,0,1);
    for (int i = 14; i <= 16; i++)
      add($sformatf("D%0d", i), 0,0, 0,0, 0,1, 190,1,3, 0,0, 0,0,1);
    add("D17", 0,0, 0,0, 0,1, 190,0,0, 1,3, 0,0,1);
    pay_cr = '{165, 140, 115, 90, 65, 40, 15, 5, 0};
    pay_cc = '{3, 3, 3, 3, 3, 3, 2, 1, 0};
    for (int i = 0; i < 9; i++)
      add($sformatf("Dpay%0d", i), 0,0, 0,0, 0,1, pay_cr[i],0,0,
          (pay_cr[i] != 0) ? 1 : 0, pay_cc[i], 0,0, (pay_cr[i] != 0) ? 1 : 0);
    add("D18", 1,2, 0,0, 0,0,  10,0,0, 0,0, 0,0,0);
    add("D19", 1,1, 0,0, 0,0,  15,0,0, 0,0, 0,0,0);
    add("D20", 1,3, 1,0, 0,0,   0,1,0, 0,0, 1,0,1);
    for (int i = 21; i <= 23; i++)
      add($sformatf("D%0d", i), 0,0, 0,0, 0,0, 0,1,0, 0,0, 0,0,1);
    add("D24", 0,0, 0,0, 0,0,   0,0,0, 0,0, 0,0,0);

    // E: credit 7, 8 quiet cycles, refund 5,1,1
    add("E1", 1,1, 0,0, 0,0,   5,0,0, 0,0, 0,0,0);
    add("E2", 1,0, 0,0, 0,0,   6,0,0, 0,0, 0,0,0);
    add("E3", 1,0, 0,0, 0,0,   7,0,0, 0,0, 0,0,0);
    for (int i = 1; i <= 7; i++)
      add($sformatf("Ewait%0d", i), 0,0, 0,0, 0,0, 7,0,0, 0,0, 0,0,0);
    add("Etmo",  0,0, 0,0, 0,0,   7,0,0, 1,1, 0,0,1);
    add("Epay1", 0,0, 0,0, 0,1,   2,0,0, 1,0, 0,0,1);
    add("Epay2", 0,0, 0,0, 0,1,   1,0,0, 1,0, 0,0,1);
    add("Epay3", 0,0, 0,0, 0,1,   0,0,0, 0,0, 0,0,0);

    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_zero("reset_release");

    foreach (vq[i]) apply(vq[i]);

    // Asynchronous reset while change is being presented
    hv = '{nm:"R1", cv:1, ct:3, sv:0, si:0, can:0, rdy:0, cr:25, dv:0, di:0, chv:0, cc:0, rej:0, err:0, bsy:0};
    apply(hv);
    hv = '{nm:"R2", cv:0, ct:0, sv:0, si:0, can:1, rdy:0, cr:25, dv:0, di:0, chv:1, cc:3, rej:0, err:0, bsy:1};
    apply(hv);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("reset_async");
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_zero("reset_after_change");
    hv = '{nm:"R3", cv:1, ct:2, sv:0, si:0, can:0, rdy:0, cr:10, dv:0, di:0, chv:0, cc:0, rej:0, err:0, bsy:0};
    apply(hv);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1);
  end

endmodule
